cnn_frame_controller: RTL and testbench

Frame-level sequencer for the `cnn` datapath. It accepts one 64×64 RGB frame from a valid/ready upstream and gates the CNN's `clk_en` so the pipeline advances only when a pixel is present and there is space for results. It flushes the pipeline after the last pixel and buffers the 49 pooled 80-bit results in a small FIFO for a backpressured downstream. It sits between the pixel source and `cnn` and owns all `clk_en` generation for it.

---
 rtl/cnn_ctrl_pkg.sv | 24 ++
 rtl/result_fifo.sv | 63 ++++++
 rtl/cnn_frame_controller.sv | 158 +++++++++++++++
 tb/tb_cnn_frame_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and sizing helpers for the CNN frame controller.
// Default frame geometry lives here so the top and any wrapper agree on it.
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_FLUSH_OUT = 2'd3
    } cnn_ctrl_state_t;

    localparam int unsigned CNN_PIXEL_WIDTH  = 24;
    localparam int unsigned CNN_IMAGE_SIZE   = 64;
    localparam int unsigned CNN_RESULT_WIDTH = 80;
    localparam int unsigned CNN_RESULT_COUNT = 49;
    localparam int unsigned CNN_FIFO_DEPTH   = 4;
    localparam int unsigned CNN_DRAIN_MAX    = 256;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO for pooled CNN results; head is shown combinationally
// and reads as zero while empty so the downstream bus is quiet between beats.
module result_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cnn_frame_controller.sv
// Frame sequencer for the cnn datapath: gates clk_en on pixel presence and result
// space, flushes the pipeline after the last pixel and buffers results for a stalled sink.
module cnn_frame_controller
    import cnn_ctrl_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH  = CNN_PIXEL_WIDTH,
    parameter int unsigned IMAGE_SIZE   = CNN_IMAGE_SIZE,
    parameter int unsigned RESULT_WIDTH = CNN_RESULT_WIDTH,
    parameter int unsigned RESULT_COUNT = CNN_RESULT_COUNT,
    parameter int unsigned FIFO_DEPTH   = CNN_FIFO_DEPTH,
    parameter int unsigned DRAIN_MAX    = CNN_DRAIN_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PIXEL_WIDTH-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PIXEL_WIDTH-1:0]  cnn_input_data,
    output logic                    cnn_clk_en,
    input  logic [RESULT_WIDTH-1:0] cnn_output_data,
    input  logic                    cnn_valid,
    output logic [RESULT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    error
);
    localparam int unsigned PIXELS = IMAGE_SIZE * IMAGE_SIZE;
    localparam int unsigned PIX_W  = cnt_width(PIXELS - 1);
    localparam int unsigned RES_W  = cnt_width(RESULT_COUNT);
    localparam int unsigned DRN_W  = cnt_width(DRAIN_MAX);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(PIXELS - 1);
    localparam logic [RES_W-1:0] RES_FULL  = RES_W'(RESULT_COUNT);
    localparam logic [DRN_W-1:0] DRN_LIMIT = DRN_W'(DRAIN_MAX);
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(FIFO_DEPTH - 2);

    cnn_ctrl_state_t    state_q, state_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
    logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
    logic               error_q, error_d;
    logic               frame_done_q, frame_done_d;
    logic               en_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [OCC_W-1:0]   fifo_count;
    logic               free_ok;
    logic               push;
    logic               pop;

    // Two free slots: one for a result that may already be in flight from the
    // previous enable, one for the result this enable may produce.
    assign free_ok = (fifo_count <= OCC_LIMIT);

    // en_q qualifies cnn_valid so a valid held across stalled cycles is taken once.
    assign push = en_q & cnn_valid & (res_cnt_q != RES_FULL) & ~fifo_full;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        res_cnt_d      = res_cnt_q;
        drn_cnt_d      = drn_cnt_q;
        error_d        = error_q;
        frame_done_d   = 1'b0;
        in_ready       = 1'b0;
        cnn_clk_en     = 1'b0;
        cnn_input_data = '0;

        if (push) res_cnt_d = res_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // The frame_done cycle is already IDLE; a start there is dropped.
                if (start && !frame_done_q) begin
                    state_d   = ST_LOAD;
                    pix_cnt_d = '0;
                    res_cnt_d = '0;
                    drn_cnt_d = '0;
                    error_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                in_ready       = free_ok;
                cnn_clk_en     = in_valid & free_ok;
                cnn_input_data = in_data;
                if (in_valid && free_ok) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_PIX) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_cnt_q == RES_FULL) begin
                    state_d = ST_FLUSH_OUT;
                end else if (drn_cnt_q == DRN_LIMIT) begin
                    error_d = 1'b1;
                    state_d = ST_FLUSH_OUT;
                end else begin
                    cnn_clk_en = free_ok;
                    if (free_ok) drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            ST_FLUSH_OUT: begin
                if (fifo_empty && !en_q) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            res_cnt_q    <= '0;
            drn_cnt_q    <= '0;
            error_q      <= 1'b0;
            frame_done_q <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            res_cnt_q    <= res_cnt_d;
            drn_cnt_q    <= drn_cnt_d;
            error_q      <= error_d;
            frame_done_q <= frame_done_d;
            en_q         <= cnn_clk_en;
        end
    end

    result_fifo #(
        .WIDTH (RESULT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (cnn_output_data),
        .pop_i       (pop),
        .head_data_o (out_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign out_valid  = ~fifo_empty;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cnn_frame_controller.sv
// Directed frame scenarios with random pixels against a CNN stub and an expected-result queue.
module tb_cnn_frame_controller;
    localparam int PW      = 24;
    localparam int IS      = 64;
    localparam int RW      = 80;
    localparam int RC      = 49;
    localparam int FD      = 4;
    localparam int DM      = 256;
    localparam int NPIX    = IS * IS;
    localparam int HIT0    = 114;
    localparam int HITSTEP = 84;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] cnn_input_data;
    logic          cnn_clk_en;
    logic [RW-1:0] cnn_output_data;
    logic          cnn_valid;
    logic [RW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          frame_done;
    logic          error;

    always #5 clk = ~clk;

    cnn_frame_controller #(
        .PIXEL_WIDTH (PW), .IMAGE_SIZE (IS), .RESULT_WIDTH (RW),
        .RESULT_COUNT (RC), .FIFO_DEPTH (FD), .DRAIN_MAX (DM)
    ) dut (
        .clk (clk), .rst (rst), .start (start),
        .in_data (in_data), .in_valid (in_valid), .in_ready (in_ready),
        .cnn_input_data (cnn_input_data), .cnn_clk_en (cnn_clk_en),
        .cnn_output_data (cnn_output_data), .cnn_valid (cnn_valid),
        .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
        .busy (busy), .frame_done (frame_done), .error (error)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [PW-1:0] pix [NPIX];
    logic [RW-1:0] exp_q [$];
    int            exp_total = 0;
    int            beats     = 0;
    int            occ       = 0;

    // Result k of a frame appears after enable number HIT0 + k*HITSTEP.
    function automatic int hit_index(input int e);
        if (e >= HIT0 && ((e - HIT0) % HITSTEP) == 0 && ((e - HIT0) / HITSTEP) < RC)
            return (e - HIT0) / HITSTEP;
        return -1;
    endfunction

    // CNN stand-in: advances only on clk_en, holds valid while stalled.
    logic          stub_clear = 1'b1;
    logic          stub_stuck = 1'b0;
    int            stub_en_cnt;
    logic [63:0]   stub_acc;
    logic          en_prev;
    int            stub_en_next;
    logic [63:0]   stub_acc_next;
    int            stub_hit;

    always_comb begin
        stub_en_next  = stub_en_cnt + 1;
        stub_acc_next = stub_acc * 64'd31 + 64'(cnn_input_data);
        stub_hit      = hit_index(stub_en_next);
    end

    always @(posedge clk) begin
        if (stub_clear) begin
            stub_en_cnt     <= 0;
            stub_acc        <= '0;
            cnn_valid       <= 1'b0;
            cnn_output_data <= '0;
            en_prev         <= 1'b0;
        end else begin
            en_prev <= cnn_clk_en;
            if (cnn_clk_en) begin
                stub_en_cnt <= stub_en_next;
                stub_acc    <= stub_acc_next;
                if (!stub_stuck && stub_hit >= 0) begin
                    cnn_valid       <= 1'b1;
                    cnn_output_data <= {16'(stub_hit), stub_acc_next};
                end else begin
                    cnn_valid <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle sampling plus output scoreboard and FIFO occupancy model.
    task automatic settle();
        #1;
        if (rst) begin
            occ = 0;
        end else begin
            check("out_valid", out_valid, occ != 0);
            if (!out_valid) check("out_data_idle", out_data, '0);
            if (out_valid && out_ready) begin
                check("beat_in_range", beats < exp_total, 1'b1);
                if (exp_q.size() > 0) check("result_data", out_data, exp_q.pop_front());
                beats++;
                occ--;
            end
            if (en_prev && cnn_valid) begin
                occ++;
                check("occupancy_le_depth", occ <= FD, 1'b1);
            end
        end
    endtask

    task automatic new_pixels();
        for (int i = 0; i < NPIX; i++) pix[i] = PW'($urandom);
    endtask

    // Expected results: a running hash of every input the CNN is clocked with.
    task automatic prep_frame();
        logic [63:0] acc;
        int k;
        exp_q.delete();
        beats = 0;
        acc   = '0;
        if (!stub_stuck) begin
            for (int e = 1; e <= HIT0 + HITSTEP * (RC - 1); e++) begin
                acc = acc * 64'd31 + 64'((e <= NPIX) ? pix[e-1] : '0);
                k = hit_index(e);
                if (k >= 0) exp_q.push_back({16'(k), acc});
            end
        end
        exp_total = exp_q.size();
    endtask

    task automatic start_frame();
        prep_frame();
        @(negedge clk); start = 1'b1; stub_clear = 1'b1; settle();
        @(negedge clk); start = 1'b0; stub_clear = 1'b0; settle();
        check("start_busy", busy, 1'b1);
        check("start_error_clear", error, 1'b0);
        check("start_in_ready", in_ready, 1'b1);
    endtask

    task automatic feed(input int prob, input int count, input bit stall);
        int idx = 0;
        int cyc = 0;
        int stalled = 0;
        int occ_now;
        bit released = !stall;
        bit release_now = 1'b0;
        if (stall) out_ready = 1'b0;
        while (idx < count) begin
            @(negedge clk);
            if (release_now) begin out_ready = 1'b1; release_now = 1'b0; end
            in_valid = ($urandom_range(99) < prob);
            in_data  = in_valid ? pix[idx] : PW'($urandom);
            occ_now  = occ;
            settle();
            check("load_in_ready", in_ready, (FD - occ_now) >= 2);
            check("load_clk_en", cnn_clk_en, in_valid & in_ready);
            check("pass_through", cnn_input_data, in_data);
            if (in_valid && !in_ready) stalled++; else stalled = 0;
            if (!released && stalled == 20) begin
                check("stall_occupancy", occ_now, FD - 1);
                released    = 1'b1;
                release_now = 1'b1;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
            if (cyc > 60000) begin
                check("feed_timeout", idx, count);
                break;
            end
        end
        if (release_now) out_ready = 1'b1;
    endtask

    task automatic finish_frame(input bit exp_err, input bit timeout_mode, input bit b2b);
        int cyc = 0;
        int den = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk); in_valid = 1'b0; in_data = '0; settle();
            check("drain_in_ready", in_ready, 1'b0);
            if (cnn_clk_en) den++;
            if (frame_done) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (cyc > 3000) begin
                    check("frame_done_timeout", frame_done, 1'b1);
                    break;
                end
            end
        end
        check("busy_at_done", busy, 1'b0);
        check("error_at_done", error, exp_err);
        check("beat_count", beats, exp_total);
        check("queue_drained", exp_q.size(), 0);
        if (timeout_mode) check("drain_cycles", den, DM);
        $display("[TB] frame done: beats=%0d drain_en=%0d error=%0b", beats, den, error);
        if (b2b) begin
            prep_frame();
            start = 1'b1; stub_clear = 1'b1;
            @(negedge clk); settle();
            check("start_ignored_busy", busy, 1'b0);
            check("frame_done_pulse", frame_done, 1'b0);
            @(negedge clk); start = 1'b0; stub_clear = 1'b0; settle();
            check("b2b_busy", busy, 1'b1);
        end else begin
            @(negedge clk); settle();
            check("frame_done_pulse", frame_done, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_clk_en"}, cnn_clk_en, 1'b0);
        check({tag, "_cnn_in"}, cnn_input_data, '0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) begin @(negedge clk); settle(); end
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0; stub_clear = 1'b0; settle();

        $display("[TB] nominal frame");
        new_pixels(); start_frame(); feed(100, NPIX, 1'b0); finish_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] downstream stall");
        new_pixels(); start_frame(); feed(100, NPIX, 1'b1); finish_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] bursty input");
        start_frame(); feed(30, NPIX, 1'b0); finish_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] drain timeout");
        stub_stuck = 1'b1;
        start_frame(); feed(100, NPIX, 1'b0); finish_frame(1'b1, 1'b1, 1'b0);
        stub_stuck = 1'b0;

        $display("[TB] reset mid-load");
        new_pixels(); start_frame(); feed(100, 1000, 1'b0);
        @(negedge clk); rst = 1'b1; stub_clear = 1'b1; in_valid = 1'b1; in_data = pix[1000]; settle();
        @(negedge clk); settle();
        check_reset_outputs("midrst");
        @(negedge clk); rst = 1'b0; stub_clear = 1'b0; in_valid = 1'b0; settle();

        $display("[TB] full frame after reset, then back-to-back");
        start_frame(); feed(100, NPIX, 1'b0); finish_frame(1'b0, 1'b0, 1'b1);
        feed(100, NPIX, 1'b0); finish_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
